// File: rtl/voice_alloc_pkg.sv
// Shared types for the voice allocator: slot-state and FSM encodings, the
// per-slot record and the candidate priority classes used while scanning.
package voice_alloc_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE      = 2'd0,
        SLOT_HELD      = 2'd1,
        SLOT_RELEASING = 2'd2
    } slot_state_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_EMIT  = 2'd2,
        ST_PANIC = 2'd3
    } fsm_state_e;

    // Slot record. The age stamp width is a module parameter, so the stamp
    // lives in a parallel array next to the table of these records.
    typedef struct packed {
        slot_state_e state;
        logic [3:0]  channel;
        logic [6:0]  note;
    } slot_info_t;

    // Candidate priority class; a lower value wins.
    typedef logic [2:0] pclass_t;
    localparam pclass_t CLS_RETRIG    = 3'd0;
    localparam pclass_t CLS_FREE      = 3'd1;
    localparam pclass_t CLS_RELEASING = 3'd2;
    localparam pclass_t CLS_HELD      = 3'd3;
    localparam pclass_t CLS_NONE      = 3'd4;

    // Priority class of one slot for the event being scheduled. A note-off
    // only cares about a HELD slot carrying the same channel and note.
    function automatic pclass_t slot_class(input slot_info_t s, input logic is_on,
                                           input logic [3:0] ch, input logic [6:0] note);
        logic match;
        match = (s.state != SLOT_FREE) && (s.channel == ch) && (s.note == note);
        if (!is_on) begin
            return (match && (s.state == SLOT_HELD)) ? CLS_RETRIG : CLS_NONE;
        end
        if (match) begin
            return CLS_RETRIG;
        end
        case (s.state)
            SLOT_FREE:      return CLS_FREE;
            SLOT_RELEASING: return CLS_RELEASING;
            default:        return CLS_HELD;
        endcase
    endfunction

endpackage

// File: rtl/voice_alloc_if.sv
// Event handshake and synth2 strobe bundle. The master side offers events
// and all_off and consumes the strobes; the allocator is the slave.
interface voice_alloc_if;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_on;
    logic [6:0] ev_note;
    logic [6:0] ev_velocity;
    logic [3:0] ev_channel;
    logic       all_off;
    logic       note_pressed;
    logic       note_released;
    logic [6:0] note;
    logic [6:0] velocity;
    logic [3:0] channel;
    logic [7:0] addr;
    logic       stolen;

    modport master (
        output ev_valid, ev_on, ev_note, ev_velocity, ev_channel, all_off,
        input  ev_ready, note_pressed, note_released, note, velocity, channel, addr, stolen
    );

    modport slave (
        input  ev_valid, ev_on, ev_note, ev_velocity, ev_channel, all_off,
        output ev_ready, note_pressed, note_released, note, velocity, channel, addr, stolen
    );
endinterface

// File: rtl/voice_alloc_pick.sv
// One scan step: weigh the current slot against the running best candidate.
// Lower class wins; within the aged classes the larger age wins; everything
// else keeps the earlier (lower-index) holder because slots arrive in order.
module voice_pick
    import voice_alloc_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int STAMP_W = 12
) (
    input  slot_info_t         i_slot,
    input  logic [STAMP_W-1:0] i_stamp,
    input  logic [IDX_W-1:0]   i_idx,
    input  logic               i_is_on,
    input  logic [3:0]         i_channel,
    input  logic [6:0]         i_note,
    input  logic [STAMP_W-1:0] i_stamp_now,
    input  logic [IDX_W-1:0]   i_best_idx,
    input  pclass_t            i_best_class,
    input  logic [STAMP_W-1:0] i_best_age,
    output logic [IDX_W-1:0]   o_best_idx,
    output pclass_t            o_best_class,
    output logic [STAMP_W-1:0] o_best_age
);
    pclass_t            w_class;
    logic [STAMP_W-1:0] w_age;
    logic               w_aged;

    assign w_class = slot_class(i_slot, i_is_on, i_channel, i_note);
    // Modular difference: correct as long as the stamp is under 2^STAMP_W events old.
    assign w_age   = i_stamp_now - i_stamp;
    assign w_aged  = (w_class == CLS_RELEASING) || (w_class == CLS_HELD);

    // Select the better of the running best and the current slot.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_best_idx   = i_best_idx;
        o_best_class = i_best_class;
        o_best_age   = i_best_age;
        if ((w_class < i_best_class) ||
            ((w_class == i_best_class) && w_aged && (w_age > i_best_age))) begin
            o_best_idx   = i_idx;
            o_best_class = w_class;
            o_best_age   = w_age;
        end
    end
endmodule

// File: rtl/voice_alloc.sv
// Voice allocator: maps note-on/note-off events onto synth2 voice slots,
// steals the oldest voice when full, and sweeps all held voices on all_off.
module voice_alloc
    import voice_alloc_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int STAMP_W    = 12
) (
    input  logic         clk32,
    input  logic         rst,
    voice_alloc_if.slave bus
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    fsm_state_e         r_state, w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_phase;
    logic               r_ev_ready;

    logic               r_ev_on;
    logic [6:0]         r_ev_note, r_ev_vel;
    logic [3:0]         r_ev_ch;

    logic [IDX_W-1:0]   r_best_idx, w_pick_idx;
    pclass_t            r_best_class, w_pick_class;
    logic [STAMP_W-1:0] r_best_age, w_pick_age;

    slot_info_t         r_slot  [NUM_VOICES];
    logic [STAMP_W-1:0] r_stamp [NUM_VOICES];
    logic [STAMP_W-1:0] r_stamp_now;

    logic               r_note_pressed, r_note_released, r_stolen;
    logic [6:0]         r_note, r_velocity;
    logic [3:0]         r_channel;
    logic [7:0]         r_addr;

    logic               w_last, w_accept, w_emit_press, w_emit_release, w_panic_fire;

    assign w_last = (r_idx == LAST_IDX);

    voice_pick #(.IDX_W(IDX_W), .STAMP_W(STAMP_W)) u_pick (
        .i_slot       (r_slot[r_idx]),
        .i_stamp      (r_stamp[r_idx]),
        .i_idx        (r_idx),
        .i_is_on      (r_ev_on),
        .i_channel    (r_ev_ch),
        .i_note       (r_ev_note),
        .i_stamp_now  (r_stamp_now),
        .i_best_idx   (r_best_idx),
        .i_best_class (r_best_class),
        .i_best_age   (r_best_age),
        .o_best_idx   (w_pick_idx),
        .o_best_class (w_pick_class),
        .o_best_age   (w_pick_age)
    );

    // all_off wins over a same-cycle event, so the offer is not acknowledged then.
    assign bus.ev_ready      = r_ev_ready && !bus.all_off;
    assign bus.note_pressed  = r_note_pressed;
    assign bus.note_released = r_note_released;
    assign bus.stolen        = r_stolen;
    assign bus.note          = r_note;
    assign bus.velocity      = r_velocity;
    assign bus.channel       = r_channel;
    assign bus.addr          = r_addr;

    // Next state and the single-cycle actions of EMIT and PANIC.
    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_emit_press   = 1'b0;
        w_emit_release = 1'b0;
        w_panic_fire   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_ev_ready && bus.all_off) begin
                    w_state_next = ST_PANIC;
                end else if (bus.ev_valid && bus.ev_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_last) w_state_next = ST_EMIT;
            end
            ST_EMIT: begin
                w_state_next   = ST_IDLE;
                w_emit_press   = r_ev_on;
                w_emit_release = !r_ev_on && (r_best_class == CLS_RETRIG);
            end
            ST_PANIC: begin
                w_panic_fire = !r_phase && (r_slot[r_idx].state == SLOT_HELD);
                if (w_last && r_phase) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM state, slot walker (one slot per SCAN cycle, two per PANIC slot) and ready flag.
    always_ff @(posedge clk32 or posedge rst) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_phase    <= 1'b0;
            r_ev_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ev_ready <= (w_state_next == ST_IDLE);
            case (r_state)
                ST_SCAN: r_idx <= w_last ? '0 : r_idx + 1'b1;
                ST_PANIC: begin
                    r_phase <= ~r_phase;
                    if (r_phase) r_idx <= w_last ? '0 : r_idx + 1'b1;
                end
                default: begin
                    r_idx   <= '0;
                    r_phase <= 1'b0;
                end
            endcase
        end
    end

    // Latch the accepted event and accumulate the best candidate during SCAN.
    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            r_ev_on      <= 1'b0;
            r_ev_note    <= '0;
            r_ev_vel     <= '0;
            r_ev_ch      <= '0;
            r_best_idx   <= '0;
            r_best_class <= CLS_NONE;
            r_best_age   <= '0;
        end else if (w_accept) begin
            // A note-on with velocity 0 is a note-off.
            r_ev_on      <= bus.ev_on && (bus.ev_velocity != 7'd0);
            r_ev_note    <= bus.ev_note;
            r_ev_vel     <= bus.ev_velocity;
            r_ev_ch      <= bus.ev_channel;
            r_best_idx   <= '0;
            r_best_class <= CLS_NONE;
            r_best_age   <= '0;
        end else if (r_state == ST_SCAN) begin
            r_best_idx   <= w_pick_idx;
            r_best_class <= w_pick_class;
            r_best_age   <= w_pick_age;
        end
    end

    // Slot table and stamp counter; slots leave FREE for good once used.
    always_ff @(posedge clk32 or posedge rst) begin
        // NOTE: the table is reset on purpose: FREE is the state every slot must start from.
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_slot[i]  <= '{state: SLOT_FREE, channel: 4'd0, note: 7'd0};
                r_stamp[i] <= '0;
            end
            r_stamp_now <= '0;
        end else begin
            if (w_emit_press) begin
                r_slot[r_best_idx]  <= '{state: SLOT_HELD, channel: r_ev_ch, note: r_ev_note};
                r_stamp[r_best_idx] <= r_stamp_now;
                r_stamp_now         <= r_stamp_now + 1'b1;
            end
            if (w_emit_release) begin
                r_slot[r_best_idx].state <= SLOT_RELEASING;
                r_stamp[r_best_idx]      <= r_stamp_now;
            end
            if (w_panic_fire) begin
                r_slot[r_idx].state <= SLOT_RELEASING;
            end
        end
    end

    // Registered strobes; data fields hold until the next strobe.
    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            r_note_pressed  <= 1'b0;
            r_note_released <= 1'b0;
            r_stolen        <= 1'b0;
            r_note          <= '0;
            r_velocity      <= '0;
            r_channel       <= '0;
            r_addr          <= '0;
        end else begin
            r_note_pressed  <= w_emit_press;
            r_note_released <= w_emit_release || w_panic_fire;
            r_stolen        <= w_emit_press && (r_best_class == CLS_HELD);
            if (w_emit_press || w_emit_release) begin
                r_note     <= r_ev_note;
                r_velocity <= r_ev_vel;
                r_channel  <= r_ev_ch;
                r_addr     <= 8'(r_best_idx);
            end else if (w_panic_fire) begin
                r_note     <= r_slot[r_idx].note;
                r_velocity <= 7'd0;
                r_channel  <= r_slot[r_idx].channel;
                r_addr     <= 8'(r_idx);
            end
        end
    end
endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc with four voices: directed walk through the
// allocation rules, all_off sweep, reset during SCAN, then random traffic
// compared against a slot-list reference model.
module tb_voice_alloc;
    localparam int N       = 4;
    localparam int STAMP_W = 12;
    localparam int MASK    = (1 << STAMP_W) - 1;
    localparam int BUDGET  = 200;
    localparam int FREE = 0, HELD = 1, REL = 2;

    logic clk32 = 1'b0;
    logic rst;
    always #5 clk32 = ~clk32;

    voice_alloc_if bus();

    voice_alloc #(.NUM_VOICES(N), .STAMP_W(STAMP_W)) dut (
        .clk32 (clk32),
        .rst   (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one entry per voice slot.
    int m_st [N];
    int m_ch [N];
    int m_nt [N];
    int m_stamp [N];
    int m_now;

    // Fields the DUT must be holding since its last strobe.
    logic [7:0] last_addr;
    logic [6:0] last_note, last_vel;
    logic [3:0] last_ch;

    // What the DUT showed in the strobe cycle of the last event.
    logic [1:0] obs_kind;
    logic [7:0] obs_addr;
    logic       obs_stolen;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = FREE; m_ch[i] = 0; m_nt[i] = 0; m_stamp[i] = 0;
        end
        m_now = 0;
        last_addr = '0; last_note = '0; last_vel = '0; last_ch = '0;
    endtask

    function automatic int oldest(input int st);
        int best = -1;
        int best_age = -1;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == st && ((m_now - m_stamp[i]) & MASK) > best_age) begin
                best = i;
                best_age = (m_now - m_stamp[i]) & MASK;
            end
        end
        return best;
    endfunction

    // kind: 0 nothing, 1 note_pressed, 2 note_released
    task automatic model_event(input bit on, input int ch, input int note, input int vel,
                               output int kind, output int addr, output bit stolen);
        int pick = -1;
        kind = 0; addr = 0; stolen = 1'b0;
        if (on && vel != 0) begin
            for (int i = 0; i < N; i++)
                if (pick < 0 && m_st[i] != FREE && m_ch[i] == ch && m_nt[i] == note) pick = i;
            for (int i = 0; i < N; i++)
                if (pick < 0 && m_st[i] == FREE) pick = i;
            if (pick < 0) pick = oldest(REL);
            if (pick < 0) begin
                pick = oldest(HELD);
                stolen = 1'b1;
            end
            kind = 1; addr = pick;
            m_st[pick] = HELD; m_ch[pick] = ch; m_nt[pick] = note; m_stamp[pick] = m_now;
            m_now = (m_now + 1) & MASK;
        end else begin
            for (int i = 0; i < N; i++)
                if (pick < 0 && m_st[i] == HELD && m_ch[i] == ch && m_nt[i] == note) pick = i;
            if (pick >= 0) begin
                kind = 2; addr = pick;
                m_st[pick] = REL; m_stamp[pick] = m_now;
            end
        end
    endtask

    // Called one step after the accept edge; ends one step after the cycle following the strobe.
    task automatic observe_strobe(input string name, input int kind, input int addr, input bit stolen,
                                  input int note, input int vel, input int ch);
        logic [28:0] exp_v, got_v;
        int busy = 0;
        if (kind != 0) begin
            last_addr = 8'(addr); last_note = 7'(note); last_vel = 7'(vel); last_ch = 4'(ch);
        end
        exp_v = {kind == 1, kind == 2, stolen, last_addr, last_note, last_vel, last_ch};
        for (int c = 1; c <= N + 1; c++) begin
            @(posedge clk32); #1;
            if (c <= N && (bus.note_pressed !== 1'b0 || bus.note_released !== 1'b0 || bus.ev_ready !== 1'b0))
                busy++;
        end
        checks++;
        if (busy != 0) begin
            errors++;
            $display("FAIL %s busy: %0d scan cycles showed a strobe or ev_ready, required 0", name, busy);
        end
        got_v = {bus.note_pressed, bus.note_released, bus.stolen, bus.addr, bus.note, bus.velocity, bus.channel};
        obs_kind = {bus.note_pressed, bus.note_released};
        obs_addr = bus.addr;
        obs_stolen = bus.stolen;
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s strobe: got {press,rel,stolen,addr,note,vel,ch}=%b,%b,%b,%0d,%0d,%0d,%0d required %b,%b,%b,%0d,%0d,%0d,%0d",
                     name, got_v[28], got_v[27], got_v[26], got_v[25:18], got_v[17:11], got_v[10:4], got_v[3:0],
                     exp_v[28], exp_v[27], exp_v[26], exp_v[25:18], exp_v[17:11], exp_v[10:4], exp_v[3:0]);
        end
        checks++;
        if (bus.ev_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_after_emit: ev_ready=%b required 1", name, bus.ev_ready);
        end
        @(posedge clk32); #1;
        checks++;
        if ({bus.note_pressed, bus.note_released, bus.stolen} !== 3'b000) begin
            errors++;
            $display("FAIL %s one_cycle: strobes %b%b%b a cycle later, required 000",
                     name, bus.note_pressed, bus.note_released, bus.stolen);
        end
    endtask

    // Called one step after a clock edge.
    task automatic send_event(input string name, input bit on, input int ch, input int note, input int vel);
        int kind, addr;
        bit st;
        int waited = 0;
        bus.ev_valid = 1'b1; bus.ev_on = on;
        bus.ev_channel = 4'(ch); bus.ev_note = 7'(note); bus.ev_velocity = 7'(vel);
        #1;
        while (bus.ev_ready !== 1'b1 && waited < BUDGET) begin
            @(posedge clk32); #2;
            waited++;
        end
        if (bus.ev_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s accept: ev_ready=%b after %0d cycles, required 1", name, bus.ev_ready, waited);
            bus.ev_valid = 1'b0;
            obs_kind = 2'bxx; obs_addr = 'x; obs_stolen = 1'bx;
            return;
        end
        @(posedge clk32); #1;
        bus.ev_valid = 1'b0;
        model_event(on, ch, note, vel, kind, addr, st);
        observe_strobe(name, kind, addr, st, note, vel, ch);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ev_valid = 1'b0; bus.ev_on = 1'b0; bus.ev_note = '0; bus.ev_velocity = '0;
        bus.ev_channel = '0; bus.all_off = 1'b0;
        model_reset();
        repeat (3) @(posedge clk32);
        #1;
        checks++;
        if ({bus.ev_ready, bus.note_pressed, bus.note_released, bus.stolen, bus.addr, bus.note,
             bus.velocity, bus.channel} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b press=%b rel=%b stolen=%b addr=%0d note=%0d vel=%0d ch=%0d required all 0",
                     bus.ev_ready, bus.note_pressed, bus.note_released, bus.stolen, bus.addr, bus.note,
                     bus.velocity, bus.channel);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.ev_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_before_edge: ev_ready=%b required 0", bus.ev_ready);
        end
        @(posedge clk32); #1;
        checks++;
        if (bus.ev_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_first_edge: ev_ready=%b required 1", bus.ev_ready);
        end
    endtask

    // Sweep with optional same-cycle event; called one step after an edge while in IDLE.
    task automatic test_panic(input string name, input bit with_event, input int ch, input int note, input int vel);
        int exp_addr[$];
        int exp_ch[$];
        int exp_nt[$];
        int seen = 0;
        int last_c = -10;
        int busy = 0;
        int kind, addr;
        bit st;
        logic [28:0] exp_v, got_v;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == HELD) begin
                exp_addr.push_back(i); exp_ch.push_back(m_ch[i]); exp_nt.push_back(m_nt[i]);
                m_st[i] = REL;
            end
        end
        bus.all_off = 1'b1;
        if (with_event) begin
            bus.ev_valid = 1'b1; bus.ev_on = 1'b1;
            bus.ev_channel = 4'(ch); bus.ev_note = 7'(note); bus.ev_velocity = 7'(vel);
        end
        #1;
        checks++;
        if (bus.ev_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s all_off_priority: ev_ready=%b required 0", name, bus.ev_ready);
        end
        @(posedge clk32); #1;
        bus.all_off = 1'b0;
        for (int c = 1; c <= 2 * N; c++) begin
            @(posedge clk32); #1;
            if (c < 2 * N && bus.ev_ready !== 1'b0) busy++;
            if (bus.note_pressed !== 1'b0) begin
                checks++; errors++;
                $display("FAIL %s panic_press: note_pressed=%b in sweep cycle %0d, required 0", name, bus.note_pressed, c);
            end
            if (bus.note_released === 1'b1) begin
                checks++;
                if (seen >= exp_addr.size()) begin
                    errors++;
                    $display("FAIL %s panic_extra: release at addr %0d cycle %0d, required none", name, bus.addr, c);
                end else begin
                    exp_v = {1'b0, 1'b1, 1'b0, 8'(exp_addr[seen]), 7'(exp_nt[seen]), 7'd0, 4'(exp_ch[seen])};
                    got_v = {bus.note_pressed, bus.note_released, bus.stolen, bus.addr, bus.note, bus.velocity, bus.channel};
                    if (got_v !== exp_v || c != 2 * exp_addr[seen] + 1) begin
                        errors++;
                        $display("FAIL %s panic_release: got addr=%0d note=%0d vel=%0d ch=%0d cycle %0d required addr=%0d note=%0d vel=0 ch=%0d cycle %0d",
                                 name, bus.addr, bus.note, bus.velocity, bus.channel, c,
                                 exp_addr[seen], exp_nt[seen], exp_ch[seen], 2 * exp_addr[seen] + 1);
                    end
                    last_addr = 8'(exp_addr[seen]); last_note = 7'(exp_nt[seen]);
                    last_vel = 7'd0; last_ch = 4'(exp_ch[seen]);
                end
                checks++;
                if (c - last_c < 2) begin
                    errors++;
                    $display("FAIL %s panic_spacing: strobes %0d cycles apart, required 2 or more", name, c - last_c);
                end
                last_c = c;
                seen++;
            end
        end
        checks++;
        if (seen != exp_addr.size()) begin
            errors++;
            $display("FAIL %s panic_count: %0d releases, required %0d", name, seen, exp_addr.size());
        end
        checks++;
        if (busy != 0 || bus.ev_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s panic_length: %0d early ready cycles, ready=%b at end, required 0 and 1",
                     name, busy, bus.ev_ready);
        end
        if (with_event) begin
            @(posedge clk32); #1;
            bus.ev_valid = 1'b0;
            model_event(1'b1, ch, note, vel, kind, addr, st);
            observe_strobe({name, "_event"}, kind, addr, st, note, vel, ch);
        end
    endtask

    task automatic test_allocation();
        int notes[4] = '{60, 62, 64, 65};
        for (int i = 0; i < 4; i++) begin
            send_event("fill", 1'b1, 0, notes[i], 100);
            checks++;
            if ({obs_kind, obs_addr, obs_stolen} !== {2'b10, 8'(i), 1'b0}) begin
                errors++;
                $display("FAIL fill_%0d: kind=%b addr=%0d stolen=%b required 10,%0d,0", i, obs_kind, obs_addr, obs_stolen, i);
            end
        end
        send_event("steal", 1'b1, 0, 67, 100);
        checks++;
        if ({obs_kind, obs_addr, obs_stolen} !== {2'b10, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL steal: kind=%b addr=%0d stolen=%b required 10,0,1", obs_kind, obs_addr, obs_stolen);
        end
        send_event("off62", 1'b0, 0, 62, 64);
        checks++;
        if ({obs_kind, obs_addr} !== {2'b01, 8'd1}) begin
            errors++;
            $display("FAIL off62: kind=%b addr=%0d required 01,1", obs_kind, obs_addr);
        end
        send_event("reuse_rel", 1'b1, 0, 69, 90);
        checks++;
        if ({obs_kind, obs_addr, obs_stolen} !== {2'b10, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL reuse_rel: kind=%b addr=%0d stolen=%b required 10,1,0", obs_kind, obs_addr, obs_stolen);
        end
        send_event("retrig", 1'b1, 0, 64, 80);
        checks++;
        if ({obs_kind, obs_addr, obs_stolen} !== {2'b10, 8'd2, 1'b0}) begin
            errors++;
            $display("FAIL retrig: kind=%b addr=%0d stolen=%b required 10,2,0", obs_kind, obs_addr, obs_stolen);
        end
    endtask

    task automatic test_note_off();
        send_event("off_unheld", 1'b0, 5, 10, 30);
        checks++;
        if (obs_kind !== 2'b00) begin
            errors++;
            $display("FAIL off_unheld: kind=%b required 00", obs_kind);
        end
        send_event("vel0_unheld", 1'b1, 0, 70, 0);
        checks++;
        if (obs_kind !== 2'b00) begin
            errors++;
            $display("FAIL vel0_unheld: kind=%b required 00", obs_kind);
        end
        send_event("vel0_held", 1'b1, 0, 65, 0);
        checks++;
        if ({obs_kind, obs_addr} !== {2'b01, 8'd3}) begin
            errors++;
            $display("FAIL vel0_held: kind=%b addr=%0d required 01,3", obs_kind, obs_addr);
        end
    endtask

    task automatic test_reset_mid_scan();
        int strobes = 0;
        bus.ev_valid = 1'b1; bus.ev_on = 1'b1; bus.ev_channel = 4'd3; bus.ev_note = 7'd50; bus.ev_velocity = 7'd40;
        @(posedge clk32); #1;
        bus.ev_valid = 1'b0;
        @(posedge clk32); #1;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk32);
        #1;
        rst = 1'b0;
        for (int c = 0; c < N + 3; c++) begin
            @(posedge clk32); #1;
            if (bus.note_pressed !== 1'b0 || bus.note_released !== 1'b0) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL rst_scan_dropped: %0d strobe cycles, required 0", strobes);
        end
        send_event("after_rst", 1'b1, 0, 72, 100);
        checks++;
        if ({obs_kind, obs_addr, obs_stolen} !== {2'b10, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL after_rst: kind=%b addr=%0d stolen=%b required 10,0,0", obs_kind, obs_addr, obs_stolen);
        end
    endtask

    task automatic test_random();
        for (int e = 0; e < 150; e++) begin
            if ($urandom_range(0, 11) == 0) begin
                test_panic("rand_panic", 1'b0, 0, 0, 0);
            end else begin
                send_event("rand", $urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom_range(60, 64),
                           ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 127));
            end
        end
    endtask

    initial begin
        test_reset();
        test_allocation();
        test_note_off();
        test_panic("panic", 1'b1, 0, 60, 100);
        checks++;
        if ({obs_kind, obs_addr, obs_stolen} !== {2'b10, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL panic_event_addr: kind=%b addr=%0d stolen=%b required 10,0,0", obs_kind, obs_addr, obs_stolen);
        end
        test_reset_mid_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
